// File: rtl/writeback_buffer.sv
// writeback_buffer: coalescing FIFO of evicted dirty cache blocks,
// drained one block at a time to data memory.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   enq_valid/ready    eviction handshake, enq_addr/enq_data payload
//   mem_wr_valid/ack   memory write, addr/data held until ack
//   lookup_addr        refill address; lookup_hit/data combinational
//   flush, flush_done  drain-all request and completion pulse
//   count              number of valid entries (0..DEPTH)
module writeback_buffer #(
    parameter int BLOCK_BITS = 1024,
    parameter int BADDR_W    = 25,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [BADDR_W-1:0]      enq_addr,
    input  logic [BLOCK_BITS-1:0]   enq_data,
    output logic                    mem_wr_valid,
    output logic [BADDR_W-1:0]      mem_wr_addr,
    output logic [BLOCK_BITS-1:0]   mem_wr_data,
    input  logic                    mem_wr_ack,
    input  logic [BADDR_W-1:0]      lookup_addr,
    output logic                    lookup_hit,
    output logic [BLOCK_BITS-1:0]   lookup_data,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state;
    logic [BADDR_W-1:0]    ent_addr [DEPTH];
    logic [BLOCK_BITS-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  flush_pending;
    logic                  live;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  enq_hit;
    logic [PW-1:0]         enq_idx;
    logic [PW-1:0]         widx;
    logic [PW-1:0]         eidx;
    logic [PW-1:0]         lidx;
    logic                  fwd_head;

    // live holds enq_ready low until the first edge after reset.
    assign enq_ready  = live && (count < FULL) && !flush_pending;
    assign accept     = enq_valid && enq_ready;
    assign push       = accept && !enq_hit;
    assign pop        = (state == WRITE) && mem_wr_ack;
    assign widx       = enq_hit ? enq_idx : tail;
    assign flush_done = flush_pending && (count == '0)
                        && (state == IDLE);
    // Head coalesced on the same edge the drain latches it.
    assign fwd_head   = accept && enq_hit && (enq_idx == head);

    // Coalesce target: youngest valid match, walking head to tail.
    // The head is excluded while it is being written.
    always_comb begin
        enq_hit = 1'b0;
        enq_idx = '0;
        eidx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            eidx = head + PW'(k);
            if (valid[eidx] && (ent_addr[eidx] == enq_addr)
                && !(k == 0 && state == WRITE)) begin
                enq_hit = 1'b1;
                enq_idx = eidx;
            end
        end
    end

    // Lookup sees registered entries only; youngest match wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lidx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lidx = head + PW'(k);
            if (valid[lidx] && (ent_addr[lidx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[lidx];
            end
        end
    end

    // Entry storage is not reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_addr[widx] <= enq_addr;
            ent_data[widx] <= enq_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            live          <= 1'b0;
            mem_wr_valid  <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
        end else begin
            live <= 1'b1;

            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end

            unique case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state        <= WRITE;
                        mem_wr_valid <= 1'b1;
                        mem_wr_addr  <= ent_addr[head];
                        mem_wr_data  <= fwd_head ? enq_data
                                                 : ent_data[head];
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        state        <= IDLE;
                        mem_wr_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush_done) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed scenario bench for writeback_buffer.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_writeback_buffer;

    localparam int BB = 1024;
    localparam int AW = 25;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_addr;
    logic [BB-1:0] enq_data;
    logic          mem_wr_valid;
    logic [AW-1:0] mem_wr_addr;
    logic [BB-1:0] mem_wr_data;
    logic          mem_wr_ack;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic [BB-1:0] lookup_data;
    logic          flush;
    logic          flush_done;
    logic [2:0]    count;

    int errors = 0;
    int checks = 0;

    writeback_buffer #(
        .BLOCK_BITS(BB),
        .BADDR_W(AW),
        .DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_addr(enq_addr),
        .enq_data(enq_data),
        .mem_wr_valid(mem_wr_valid),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack),
        .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit),
        .lookup_data(lookup_data),
        .flush(flush),
        .flush_done(flush_done),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [BB-1:0] pat(input logic [31:0] s);
        return {32{s}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(output bit ok);
        for (int i = 0; i < 20 && !mem_wr_valid; i++) tick();
        ok = mem_wr_valid;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_valid: got %b want 0", mem_wr_valid);
        end
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_enq_ready: got %b want 0", enq_ready);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL rst_count: got %0d want 0", count);
        end
        checks++;
        if (lookup_hit !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_hit_done: got %b%b want 00",
                     lookup_hit, flush_done);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL rel_ready_early: got %b want 0", enq_ready);
        end
        tick();
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_ready: got %b want 1", enq_ready);
        end
    endtask

    task automatic test_single;
        bit stable;
        enq_valid = 1'b1;
        enq_addr  = 25'h10;
        enq_data  = pat(32'hA0A0_0001);
        tick();
        enq_valid = 1'b0;
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL single_count1: got %0d want 1", count);
        end
        checks++;
        if (mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got %b want 0", mem_wr_valid);
        end
        tick();
        checks++;
        if (mem_wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: got %b want 1", mem_wr_valid);
        end
        checks++;
        if (mem_wr_addr !== 25'h10
            || mem_wr_data !== pat(32'hA0A0_0001)) begin
            errors++;
            $display("FAIL single_payload: got %h/%h want 10/a0a00001",
                     mem_wr_addr, mem_wr_data[31:0]);
        end
        stable = 1'b1;
        repeat (2) begin
            tick();
            if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 25'h10
                || mem_wr_data !== pat(32'hA0A0_0001))
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL single_stable: got unstable want stable");
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got cnt=%0d v=%b want 0/0",
                     count, mem_wr_valid);
        end
    endtask

    task automatic test_fill;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_addr  = 25'h40 + AW'(i);
            enq_data  = pat(32'hF000_0000 | i);
            tick();
        end
        enq_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b want 4/0",
                     count, enq_ready);
        end
        enq_valid = 1'b1;
        enq_addr  = 25'h44;
        enq_data  = pat(32'hDEAD_BEEF);
        tick();
        enq_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_overflow: got %0d want 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            wait_wr(ok);
            checks++;
            if (!ok || mem_wr_addr !== 25'h40 + AW'(i)
                || mem_wr_data !== pat(32'hF000_0000 | i)) begin
                errors++;
                $display("FAIL fill_order%0d: got v=%b %h/%h want %h",
                         i, ok, mem_wr_addr, mem_wr_data[31:0],
                         25'h40 + AW'(i));
            end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
            if (i == 0) begin
                checks++;
                if (count !== 3'd3 || enq_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_pop1: got %0d/%b want 3/1",
                             count, enq_ready);
                end
            end
            checks++;
            if (mem_wr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_gap%0d: got %b want 0",
                         i, mem_wr_valid);
            end
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_coalesce;
        bit ok;
        // Second enqueue lands while the FSM is still IDLE.
        enq_valid = 1'b1;
        enq_addr  = 25'h20;
        enq_data  = pat(32'hAAAA_0000);
        tick();
        enq_data  = pat(32'hBBBB_0000);
        tick();
        enq_valid = 1'b0;
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL coal_idle_cnt: got %0d want 1", count);
        end
        checks++;
        if (mem_wr_valid !== 1'b1
            || mem_wr_data !== pat(32'hBBBB_0000)) begin
            errors++;
            $display("FAIL coal_idle_data: got %b/%h want 1/bbbb0000",
                     mem_wr_valid, mem_wr_data[31:0]);
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL coal_idle_end: got %0d want 0", count);
        end
        // Head already in WRITE: append, then coalesce the new one.
        enq_valid = 1'b1;
        enq_data  = pat(32'hAAAA_1111);
        tick();
        enq_valid = 1'b0;
        tick();
        enq_valid = 1'b1;
        enq_data  = pat(32'hCCCC_1111);
        tick();
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL coal_wr_append: got %0d want 2", count);
        end
        enq_data = pat(32'hBBBB_1111);
        tick();
        enq_valid = 1'b0;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL coal_wr_merge: got %0d want 2", count);
        end
        checks++;
        if (mem_wr_data !== pat(32'hAAAA_1111)) begin
            errors++;
            $display("FAIL coal_wr_first: got %h want aaaa1111",
                     mem_wr_data[31:0]);
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        wait_wr(ok);
        checks++;
        if (!ok || mem_wr_addr !== 25'h20
            || mem_wr_data !== pat(32'hBBBB_1111)) begin
            errors++;
            $display("FAIL coal_wr_last: got %b %h/%h want 20/bbbb1111",
                     ok, mem_wr_addr, mem_wr_data[31:0]);
        end
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
    endtask

    task automatic test_lookup;
        bit ok;
        logic [AW-1:0] ea [3];
        logic [31:0]   ed [3];
        ea[0] = 25'h30; ed[0] = 32'hC0C0_0030;
        ea[1] = 25'h32; ed[1] = 32'hF0F0_0032;
        ea[2] = 25'h30; ed[2] = 32'hE0E0_0030;
        enq_valid = 1'b1;
        enq_addr  = ea[0];
        enq_data  = pat(ed[0]);
        tick();
        enq_valid = 1'b0;
        lookup_addr = 25'h30;
        #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== pat(ed[0])) begin
            errors++;
            $display("FAIL lookup_hit: got %b/%h want 1/c0c00030",
                     lookup_hit, lookup_data[31:0]);
        end
        lookup_addr = 25'h31;
        #1;
        checks++;
        if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
            errors++;
            $display("FAIL lookup_miss: got %b/%h want 0/0",
                     lookup_hit, lookup_data[31:0]);
        end
        tick();
        lookup_addr = ea[1];
        enq_valid   = 1'b1;
        enq_addr    = ea[1];
        enq_data    = pat(ed[1]);
        #1;
        checks++;
        if (lookup_hit !== 1'b0) begin
            errors++;
            $display("FAIL lookup_same_cycle: got %b want 0", lookup_hit);
        end
        tick();
        enq_addr = ea[2];
        enq_data = pat(ed[2]);
        #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== pat(ed[1])) begin
            errors++;
            $display("FAIL lookup_after_enq: got %b/%h want 1/f0f00032",
                     lookup_hit, lookup_data[31:0]);
        end
        tick();
        enq_valid   = 1'b0;
        lookup_addr = 25'h30;
        #1;
        checks++;
        if (count !== 3'd3 || lookup_data !== pat(ed[2])) begin
            errors++;
            $display("FAIL lookup_youngest: got %0d/%h want 3/e0e00030",
                     count, lookup_data[31:0]);
        end
        for (int i = 0; i < 3; i++) begin
            wait_wr(ok);
            checks++;
            if (!ok || mem_wr_addr !== ea[i]
                || mem_wr_data !== pat(ed[i])) begin
                errors++;
                $display("FAIL lookup_drain%0d: got %b %h/%h want %h/%h",
                         i, ok, mem_wr_addr, mem_wr_data[31:0],
                         ea[i], ed[i]);
            end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
    endtask

    task automatic test_flush;
        int nwr;
        int ndone;
        bit early;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_addr  = 25'h50 + AW'(i);
            enq_data  = pat(32'h5000_0000 | i);
            tick();
        end
        enq_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_low: got %b want 0", enq_ready);
        end
        nwr   = 0;
        ndone = 0;
        early = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (flush_done) ndone++;
            if (enq_ready && ndone == 0) early = 1'b1;
            if (mem_wr_valid) begin
                nwr++;
                mem_wr_ack = 1'b1;
            end
            tick();
            mem_wr_ack = 1'b0;
        end
        checks++;
        if (nwr != 3) begin
            errors++;
            $display("FAIL flush_writes: got %0d want 3", nwr);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL flush_pulses: got %0d want 1", ndone);
        end
        checks++;
        if (early || enq_ready !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL flush_end: got early=%b rdy=%b cnt=%0d",
                     early, enq_ready, count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (flush_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got %b want 1", flush_done);
        end
        tick();
        checks++;
        if (flush_done !== 1'b0 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty_end: got %b/%b want 0/1",
                     flush_done, enq_ready);
        end
    endtask

    task automatic test_reset_write;
        enq_valid = 1'b1;
        enq_addr  = 25'h60;
        enq_data  = pat(32'h6060_6060);
        tick();
        enq_valid = 1'b0;
        tick();
        checks++;
        if (mem_wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstw_pre: got %b want 1", mem_wr_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_wr_valid !== 1'b0 || enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstw_async: got v=%b rdy=%b want 0/0",
                     mem_wr_valid, enq_ready);
        end
        tick();
        rst = 1'b0;
        lookup_addr = 25'h60;
        #1;
        checks++;
        if (count !== 3'd0 || lookup_hit !== 1'b0) begin
            errors++;
            $display("FAIL rstw_after: got cnt=%0d hit=%b want 0/0",
                     count, lookup_hit);
        end
        tick();
        checks++;
        if (enq_ready !== 1'b1 || mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_resume: got rdy=%b v=%b want 1/0",
                     enq_ready, mem_wr_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        enq_valid   = 1'b0;
        enq_addr    = '0;
        enq_data    = '0;
        mem_wr_ack  = 1'b0;
        lookup_addr = '0;
        flush       = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_coalesce();
        test_lookup();
        test_flush();
        test_reset_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
Parameters:
REQ-001 The block SHALL have parameter BLOCK_BITS, default 1024, giving the cache block width in bits (128 bytes).
REQ-002 The block SHALL have parameter BADDR_W, default 25, giving the block address width (word address bits [31:7]).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the number of entries; DEPTH SHALL be a power of two.

Ports:
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enq_valid  in  1  the data cache presents an evicted dirty block.
REQ-007 enq_ready  out  1  the buffer accepts the block this cycle.
REQ-008 enq_addr  in  BADDR_W  block address of the evicted block.
REQ-009 enq_data  in  BLOCK_BITS  evicted block contents.
REQ-010 mem_wr_valid  out  1  write request to data memory.
REQ-011 mem_wr_addr  out  BADDR_W  block address of the write.
REQ-012 mem_wr_data  out  BLOCK_BITS  block data of the write.
REQ-013 mem_wr_ack  in  1  data memory has completed the write.
REQ-014 lookup_addr  in  BADDR_W  block address of a cache refill, checked against the buffer.
REQ-015 lookup_hit  out  1  lookup_addr matches a valid entry (combinational).
REQ-016 lookup_data  out  BLOCK_BITS  data of the youngest matching entry; zero when there is no hit.
REQ-017 flush  in  1  one-cycle request to drain all entries.
REQ-018 flush_done  out  1  one-cycle pulse when the flush completes.
REQ-019 count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-020 Storage SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH; count SHALL track occupancy from 0 to DEPTH.
REQ-021 enq_ready SHALL be 1 when count<DEPTH and no flush is pending; there SHALL be no bypass when full, even if a pop occurs in the same cycle.
REQ-022 Accept rule: when enq_valid && enq_ready and enq_addr equals a valid non-head entry, or equals the head while the drain FSM is in IDLE, the entry's data SHALL be overwritten in place (coalesce) and count SHALL be unchanged.
REQ-023 When an accepted block has no coalesce match, it SHALL be written at tail, tail SHALL advance, and count SHALL increment.
REQ-024 The drain FSM SHALL have exactly two states, IDLE and WRITE.
  - IDLE -> WRITE when count>0.
  - In WRITE: mem_wr_valid=1; mem_wr_addr and mem_wr_data SHALL hold the head entry and stay stable until mem_wr_ack.
  - WRITE -> IDLE on mem_wr_ack: head is invalidated, head advances, count decrements.
  - mem_wr_ack in IDLE SHALL be ignored.
REQ-025 Latency: a block enqueued into an empty buffer at edge N SHALL produce mem_wr_valid=1 after edge N+1; consecutive writes SHALL have at least one idle cycle between them.
REQ-026 The head entry SHALL NOT be coalesced while in WRITE; a matching enqueue in that case SHALL append a new entry.
REQ-027 Enqueue and pop in the same cycle SHALL leave count unchanged and both pointers advanced.
REQ-028 lookup_hit and lookup_data SHALL reflect registered state only; a same-cycle enqueue SHALL NOT be visible.
REQ-029 When a lookup matches multiple entries, the youngest entry SHALL win.
REQ-030 A flush pulse SHALL set flush_pending.
  - flush_done SHALL pulse for one cycle once flush_pending is set, count==0 and the FSM is in IDLE; flush_pending then clears.
  - A flush with an already empty buffer SHALL pulse flush_done on the next cycle.
  - A flush while flush_pending is set SHALL be ignored.

Reset
REQ-031 While rst is high, immediately and asynchronously: head, tail and count SHALL be 0; all valid bits 0; FSM in IDLE; flush_pending 0; mem_wr_valid, flush_done, lookup_hit 0; enq_ready 0. Entry data SHALL NOT be reset.
REQ-032 Reset during WRITE SHALL drop mem_wr_valid immediately; buffered blocks are discarded.
REQ-033 enq_ready SHALL rise on the first clock edge after rst falls.

Verification
REQ-034 Single write: enqueue addr 0x10 with data pattern A, ack after 3 cycles -> mem_wr_valid rises one cycle after the enqueue, addr 0x10 and data A are held stable, count goes 1->0, then mem_wr_valid=0.
REQ-035 Fill, then overflow: hold mem_wr_ack=0 and enqueue 4 distinct addresses -> count=4, enq_ready=0; a 5th enqueue is not accepted; the next ack gives count=3, enq_ready=1; drain order matches enqueue order with wrap-around verified.
REQ-036 Coalesce: enqueue 0x20 (data A) then 0x20 (data B) before the first ack -> count stays 1 if the head is not yet in WRITE, else becomes 2; memory sees B last in both cases.
REQ-037 Lookup: buffer holds 0x30 (data C) -> lookup 0x30 gives hit=1, data=C; lookup 0x31 gives hit=0, data=0.
REQ-038 Flush: 3 entries plus a flush pulse -> enq_ready=0, all 3 drained, a single flush_done pulse, then enq_ready=1.
REQ-039 Reset in WRITE: assert rst with mem_wr_valid=1 -> mem_wr_valid=0 before the next edge; count=0 and lookup_hit=0 after release.
